debounce_multi: RTL

- Parametrised multi-channel push-button conditioner; the successor to the single-channel 4-sample debouncer.
- Per channel: 2-flop synchroniser, WIN-sample debounce with hysteresis, one-cycle press/release pulses, and a long-press detector.
- Optional auto-repeat is compiled in by macro.
- Sits between raw board buttons and the control FSMs (timer start/stop, set keys), all on clk_f.

---
 rtl/debounce_multi.sv | 127 ++++++++++++
 1 files changed

// File: rtl/debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, WIN-sample hysteresis debounce,
// press/release pulses, long-press pulse and optional auto-repeat.
// Optional auto-repeat is compiled in with `define DEBOUNCE_AUTO_REPEAT_EN; otherwise pb_rep is tied 0.
// Latency: pb_in stable from edge E0 shows on pb_de after edge E0+WIN+1; no backpressure.
module debounce_multi #(
  parameter int CH       = 4,
  parameter int WIN      = 4,
  parameter int HOLD_CYC = 512,
  parameter int REP_CYC  = 128
) (
  input  logic          clk_f,
  input  logic          rst,
  input  logic [CH-1:0] pb_in,
  output logic [CH-1:0] pb_de,
  output logic [CH-1:0] pb_rise,
  output logic [CH-1:0] pb_fall,
  output logic [CH-1:0] pb_long,
  output logic [CH-1:0] pb_rep
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYC - 1);

  logic [CH-1:0] sync_a;
  logic [CH-1:0] sync_b;

  // Two-flop synchroniser for the raw asynchronous button levels
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= pb_in;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [WIN-1:0] win_q;
    logic [WIN-1:0] win_next;
    logic           de_q;
    logic           de_next;
    logic           rise_q;
    logic           fall_q;
    logic           long_q;
    logic [HW-1:0]  hold_q;

    // The level decision looks at the window as it will be after this edge,
    // which is what gives the E0+WIN+1 latency rather than one cycle more.
    assign win_next = {win_q[WIN-2:0], sync_b[i]};
    assign de_next  = (&win_next) | (de_q & (|win_next));

    // Sample window, hysteresis level and its edge pulses
    always_ff @(posedge clk_f or posedge rst) begin
      if (rst) begin
        win_q  <= '0;
        de_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        win_q  <= win_next;
        de_q   <= de_next;
        rise_q <= ~de_q & de_next;
        fall_q <= de_q & ~de_next;
      end
    end

    // Long-press counter: counts debounced-high edges, saturating so the pulse fires once per press
    always_ff @(posedge clk_f or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= de_q & (hold_q == HOLD_PRE);
        if (!de_q) begin
          hold_q <= '0;
        end else if (hold_q != HOLD_MAX) begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end

    assign pb_de[i]   = de_q;
    assign pb_rise[i] = rise_q;
    assign pb_fall[i] = fall_q;
    assign pb_long[i] = long_q;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
    localparam int RW = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REP_CYC - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_q;

    // Auto-repeat: first pulse with the long-press, then every REP_CYC edges while
    // the button stays down; no pulse on the edge that releases it.
    always_ff @(posedge clk_f or posedge rst) begin
      if (rst) begin
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else if (!de_q) begin
        rep_cnt <= '0;
        rep_q   <= 1'b0;
      end else if (hold_q == HOLD_PRE) begin
        rep_cnt <= '0;
        rep_q   <= de_next;
      end else if (hold_q == HOLD_MAX) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
          rep_q   <= de_next;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
          rep_q   <= 1'b0;
        end
      end else begin
        rep_q <= 1'b0;
      end
    end

    assign pb_rep[i] = rep_q;
`else
    assign pb_rep[i] = 1'b0;
`endif
  end

endmodule
